filter_accel_div_seq: RTL and testbench
=======================================

Name: filter_accel_div_seq

Overview:
- Sequential inverse of the filter datapath's signed×unsigned product stage (8-bit signed × 10-bit unsigned → 18-bit signed).
- Divides an 18-bit signed value by a 10-bit unsigned divisor and returns a saturated 8-bit signed quotient and a signed remainder.
- Used by the pre-motion-correction filter to recover normalised coefficients and pixel scales.
- Radix-2 restoring divider with ap_ctrl_hs-style start/done handshake.

Parameters:
- DIVIDEND_W, 18, dividend width (signed).
- DIVISOR_W, 10, divisor width (unsigned).
- QUOT_W, 8, quotient width (signed, saturated).

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst  in  1  reset; asynchronous, active-high.
- ap_start  in  1  request; operands sampled when accepted.
- ap_ready  out  1  combinational: ap_idle & ap_start (acceptance cycle).
- ap_idle  out  1  high in IDLE.
- ap_done  out  1  one-cycle pulse; results valid.
- din0  in  DIVIDEND_W  dividend, signed.
- din1  in  DIVISOR_W  divisor, unsigned.
- quot  out  QUOT_W  quotient, signed.
- rem  out  DIVISOR_W+1  remainder, signed; rem = din0 − quot·din1 unless saturated or div-by-zero.
- ovf  out  1  quotient saturated.
- div_zero  out  1  din1 was 0.

Behaviour:
- Reset, async and any cycle including mid-operation:
  - state := IDLE; quot, rem, ovf, div_zero, ap_done := 0; iteration counter := 0.
  - ap_idle = 1 once reset is asserted; no ap_done for an aborted operation.
- States:
  - IDLE: ap_start = 1 at edge E0 latches |din0|, the dividend sign, and din1 → CALC, counter := DIVIDEND_W−1.
  - CALC: one restoring step per cycle (shift partial remainder left, bring in the next dividend MSB, trial-subtract the divisor, keep if non-negative, shift the quotient bit in). Counter decrements; at 0 → FIX. Occupies DIVIDEND_W cycles (edges E1..E18).
  - FIX (edge E19):
    - Apply signs: quotient negative iff dividend negative and divisor ≠ 0.
    - Remainder takes the dividend's sign (truncation toward zero).
    - Saturate to [−2^(QUOT_W−1), 2^(QUOT_W−1)−1]; set ovf if clamped.
    - Register outputs → DONE.
  - DONE: ap_done = 1 for exactly this cycle → IDLE at E20.
- Latency: ap_done visible in the cycle after edge E(DIVIDEND_W+1). Minimum issue interval DIVIDEND_W+3 cycles (21 at default).
- ap_start while not IDLE: ignored; operand changes during an operation have no effect.
- Divide by zero: no iteration special-casing; FIX forces quot = 2^(QUOT_W−1)−1 if din0 ≥ 0, else −2^(QUOT_W−1); rem = 0; div_zero = 1; ovf = 0.
- Saturated result: rem = 0.
- quot/rem/ovf/div_zero hold stable from DONE until the next FIX or reset.
- Dividend −2^(DIVIDEND_W−1): magnitude is held in DIVIDEND_W bits unsigned, with no overflow.
- Round-trip invariant: for a in [−128,127] and b in [1,1023], div(a·b, b) = (a, rem 0, ovf 0).

Optional Feature:
- Macro: FILTER_ACCEL_DIV_ROUND_EN.
- Defined: FIX rounds half away from zero. If 2·|rem_trunc| ≥ din1, |quot| += 1 and rem = din0 − quot·din1 (sign may flip). Saturation and ovf are evaluated after rounding. Latency unchanged.
- Undefined: truncation toward zero only.

Test Plan:
- din0 = −5000, din1 = 1000, ap_start pulse at E0 → ap_ready = 1 in the E0 cycle; ap_done only after E19; quot = −5, rem = 0, ovf = 0, div_zero = 0.
- din0 = 7, din1 = 2 → quot = 3, rem = 1; din0 = −7 → quot = −3, rem = −1. With FILTER_ACCEL_DIV_ROUND_EN: 4/−1 and −4/1 respectively.
- din0 = 131071, din1 = 1 → quot = 127, ovf = 1, rem = 0; din0 = −131072, din1 = 3 → quot = −128, ovf = 1.
- din0 = 1000, din1 = 0 → quot = 127, div_zero = 1; din0 = −1, din1 = 0 → quot = −128, div_zero = 1.
- Start op (din0 = 500, din1 = 5), assert ap_rst asynchronously mid-cycle at cycle 10 → outputs 0, ap_idle = 1, no ap_done. Release and restart → quot = 100 after 20 edges.
- ap_start held high, operands from a random a·b stream (1000 pairs) → ap_done every 21 cycles; each result equals a, rem 0; ap_start during busy ignored.

Source files
------------

// File: rtl/filter_accel_div_seq.sv
// Radix-2 restoring divider: signed dividend / unsigned divisor -> saturated signed quotient.
// Define FILTER_ACCEL_DIV_ROUND_EN to round half away from zero instead of truncating.
module filter_accel_div_seq #(
  parameter int DIVIDEND_W = 18,
  parameter int DIVISOR_W  = 10,
  parameter int QUOT_W     = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic [DIVIDEND_W-1:0] din0,
  input  logic [DIVISOR_W-1:0]  din1,
  output logic [QUOT_W-1:0]     quot,
  output logic [DIVISOR_W:0]    rem,
  output logic                  ovf,
  output logic                  div_zero
);
  localparam int CNT_W  = $clog2(DIVIDEND_W);
  localparam int PR_W   = DIVISOR_W + 1;
  localparam int MAGQ_W = DIVIDEND_W + 1;
  localparam int QMAX   = 2**(QUOT_W-1) - 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;
  state_e r_state, w_state_next;

  logic [CNT_W-1:0]      r_cnt;
  logic [DIVIDEND_W-1:0] r_dvd, r_q;
  logic [DIVISOR_W-1:0]  r_dvs;
  logic [PR_W-1:0]       r_pr;
  logic                  r_neg;
  logic [QUOT_W-1:0]     r_quot;
  logic [PR_W-1:0]       r_rem;
  logic                  r_ovf, r_div_zero;

  logic [DIVIDEND_W-1:0] w_abs;
  logic [PR_W-1:0]       w_shift;
  logic [PR_W:0]         w_trial;
  logic                  w_qbit;
  logic [MAGQ_W-1:0]     w_mag_q;
  logic [PR_W-1:0]       w_rem_mag, w_rem_s;
  logic [QUOT_W-1:0]     w_quot, w_quot_s, w_quot_lim;
  logic [PR_W-1:0]       w_rem;
  logic                  w_ovf, w_div_zero, w_sat;

  assign w_abs   = din0[DIVIDEND_W-1] ? (~din0 + DIVIDEND_W'(1)) : din0;
  assign w_shift = {r_pr[DIVISOR_W-1:0], r_dvd[DIVIDEND_W-1]};
  assign w_trial = {1'b0, w_shift} - {2'b00, r_dvs};
  assign w_qbit  = ~w_trial[PR_W];

  // Sign application, optional rounding and saturation on the unsigned magnitudes.
  always_comb begin
    w_mag_q   = {1'b0, r_q};
    w_rem_mag = r_pr;
`ifdef FILTER_ACCEL_DIV_ROUND_EN
    if ({r_pr[DIVISOR_W-1:0], 1'b0} >= {1'b0, r_dvs}) begin
      w_mag_q   = w_mag_q + MAGQ_W'(1);
      w_rem_mag = r_pr - {1'b0, r_dvs};
    end
`endif
    w_rem_s    = r_neg ? (~w_rem_mag + PR_W'(1)) : w_rem_mag;
    w_quot_s   = r_neg ? (~w_mag_q[QUOT_W-1:0] + QUOT_W'(1)) : w_mag_q[QUOT_W-1:0];
    w_quot_lim = r_neg ? {1'b1, {(QUOT_W-1){1'b0}}} : {1'b0, {(QUOT_W-1){1'b1}}};
    w_sat      = r_neg ? (w_mag_q > MAGQ_W'(QMAX + 1)) : (w_mag_q > MAGQ_W'(QMAX));
    w_div_zero = (r_dvs == '0);
    w_quot     = w_quot_s;
    w_rem      = w_rem_s;
    w_ovf      = 1'b0;
    if (w_div_zero) begin
      w_quot = w_quot_lim;
      w_rem  = '0;
    end else if (w_sat) begin
      w_quot = w_quot_lim;
      w_rem  = '0;
      w_ovf  = 1'b1;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (ap_start) w_state_next = StCalc;
      StCalc:  if (r_cnt == '0) w_state_next = StFix;
      StFix:   w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    ap_idle  = (r_state == StIdle);
    ap_done  = (r_state == StDone);
    ap_ready = ap_idle & ap_start;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_cnt      <= '0;
      r_dvd      <= '0;
      r_q        <= '0;
      r_dvs      <= '0;
      r_pr       <= '0;
      r_neg      <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_ovf      <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: if (ap_start) begin
          r_dvd <= w_abs;
          r_neg <= din0[DIVIDEND_W-1];
          r_dvs <= din1;
          r_pr  <= '0;
          r_q   <= '0;
          r_cnt <= CNT_W'(DIVIDEND_W - 1);
        end
        StCalc: begin
          r_pr  <= w_qbit ? w_trial[PR_W-1:0] : w_shift;
          r_dvd <= r_dvd << 1;
          r_q   <= {r_q[DIVIDEND_W-2:0], w_qbit};
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
        StFix: begin
          r_quot     <= w_quot;
          r_rem      <= w_rem;
          r_ovf      <= w_ovf;
          r_div_zero <= w_div_zero;
        end
        default: ;
      endcase
    end
  end

  assign quot     = r_quot;
  assign rem      = r_rem;
  assign ovf      = r_ovf;
  assign div_zero = r_div_zero;
endmodule

// File: tb/tb_filter_accel_div_seq.sv
// Directed and round-trip checks for filter_accel_div_seq (default widths 18/10/8).
module tb_filter_accel_div_seq;
  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_ready, ap_idle, ap_done;
  logic [17:0] din0;
  logic [9:0]  din1;
  logic [7:0]  quot;
  logic [10:0] rem;
  logic        ovf, div_zero;

  int n_checks = 0;
  int n_fail   = 0;

  filter_accel_div_seq dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .ap_start (ap_start),
    .ap_ready (ap_ready),
    .ap_idle  (ap_idle),
    .ap_done  (ap_done),
    .din0     (din0),
    .din1     (din1),
    .quot     (quot),
    .rem      (rem),
    .ovf      (ovf),
    .div_zero (div_zero)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input int q, input int r, input int o, input int z);
    check({tag, ".quot"}, $signed(quot), q);
    check({tag, ".rem"}, $signed(rem), r);
    check({tag, ".ovf"}, ovf, o);
    check({tag, ".div_zero"}, div_zero, z);
  endtask

  // Issue one operation and wait for ap_done; done must appear 20 negedges after the start one.
  task automatic do_op(input string tag, input int a, input int b);
    int n;
    @(negedge ap_clk);
    din0     = 18'(a);
    din1     = 10'(b);
    ap_start = 1'b1;
    #1 check({tag, ".ready"}, ap_ready, 1);
    @(negedge ap_clk);
    ap_start = 1'b0;
    n = 1;
    while (!ap_done && n < 40) begin
      @(negedge ap_clk);
      n++;
    end
    check({tag, ".latency"}, n, 20);
  endtask

  initial begin
    int q_exp[$];
    int a, b, p, ndone, since, seen, exp_a;

    ap_rst   = 1'b1;
    ap_start = 1'b0;
    din0     = '0;
    din1     = '0;
    #3;
    check("rst.quot", quot, 0);
    check("rst.idle", ap_idle, 1);
    check("rst.done", ap_done, 0);
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;

    do_op("neg5", -5000, 1000);
    check_res("neg5", -5, 0, 0, 0);
`ifdef FILTER_ACCEL_DIV_ROUND_EN
    do_op("p7d2", 7, 2);
    check_res("p7d2", 4, -1, 0, 0);
    do_op("m7d2", -7, 2);
    check_res("m7d2", -4, 1, 0, 0);
`else
    do_op("p7d2", 7, 2);
    check_res("p7d2", 3, 1, 0, 0);
    do_op("m7d2", -7, 2);
    check_res("m7d2", -3, -1, 0, 0);
`endif
    do_op("satp", 131071, 1);
    check_res("satp", 127, 0, 1, 0);
    do_op("satn", -131072, 3);
    check_res("satn", -128, 0, 1, 0);
    do_op("dz_p", 1000, 0);
    check_res("dz_p", 127, 0, 0, 1);
    do_op("dz_n", -1, 0);
    check_res("dz_n", -128, 0, 0, 1);
    // Outputs must hold after DONE.
    repeat (3) @(negedge ap_clk);
    check("hold.quot", $signed(quot), -128);

    // Async reset mid-operation.
    @(negedge ap_clk);
    din0     = 18'(500);
    din1     = 10'(5);
    ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    repeat (9) @(negedge ap_clk);
    #2 ap_rst = 1'b1;
    #1;
    check("abort.quot", quot, 0);
    check("abort.div_zero", div_zero, 0);
    check("abort.idle", ap_idle, 1);
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge ap_clk);
      if (ap_done) seen++;
    end
    check("abort.no_done", seen, 0);
    do_op("restart", 500, 5);
    check_res("restart", 100, 0, 0, 0);

    // Round-trip stream with ap_start held; operands churn every busy cycle.
    a = int'($urandom_range(255)) - 128;
    b = int'($urandom_range(1022)) + 1;
    p = a * b;
    @(negedge ap_clk);
    din0     = 18'(p);
    din1     = 10'(b);
    exp_a    = a;
    ap_start = 1'b1;
    ndone    = 0;
    since    = 0;
    for (int cyc = 0; cyc < 25000 && ndone < 1000; cyc++) begin
      #1;
      since++;
      if (ap_done) begin
        if (q_exp.size() == 0) begin
          check("rt.queue", 0, 1);
        end else begin
          int e;
          e = q_exp.pop_front();
          check("rt.quot", $signed(quot), e);
          check("rt.rem", $signed(rem), 0);
          check("rt.ovf", ovf, 0);
        end
        if (ndone > 0) check("rt.interval", since, 21);
        since = 0;
        ndone++;
      end
      if (ap_ready) begin
        q_exp.push_back(exp_a);
      end else begin
        a     = int'($urandom_range(255)) - 128;
        b     = int'($urandom_range(1022)) + 1;
        p     = a * b;
        din0  = 18'(p);
        din1  = 10'(b);
        exp_a = a;
      end
      @(negedge ap_clk);
    end
    ap_start = 1'b0;
    check("rt.count", ndone, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
